tri_cos_param: RTL and testbench

Parametrised triangle classifier and cosine engine, the next generation of the fixed 8-bit/Q2.13 triangle block. It accepts three side lengths serially and returns the triangle type plus the cosine of the angle opposite each side as a three-cycle output burst. Generalisations:
- length width and output fixed-point format are parameters;
- degenerate and invalid triangles are detected;
- an aborted input sequence is discarded;
- inputs arriving while busy are ignored.

It sits behind the geometry front-end and feeds the shape-statistics logic.

---
 rtl/tri_cos_param.sv | 180 ++++++++++++++++++
 tb/tb_tri_cos_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tri_cos_param.sv
// Triangle classifier and cosine engine: three serial side lengths in, triangle
// type plus the three cosines out as a registered three-cycle burst.
module tri_cos_param #(
    parameter int LEN_W  = 8,
    parameter int COS_W  = 16,
    parameter int FRAC_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [LEN_W-1:0] in_length,
    output logic             out_valid,
    output logic [COS_W-1:0] out_cos,
    output logic [1:0]       out_tri
);
    // Handshake: no back-pressure. in_valid marks three consecutive length
    // beats accepted only from IDLE; out_valid marks three consecutive result beats.
    localparam int NUM_W  = 2*LEN_W + 2;
    localparam int DEN_W  = 2*LEN_W + 1;
    localparam int Q_W    = FRAC_W + 1;
    localparam int STEP_W = $clog2(FRAC_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAC_W);

    typedef enum logic [2:0] {IDLE, LOAD, PREP, DIV, OUT} state_t;
    state_t state, state_nx;

    logic [LEN_W-1:0]        len_a, len_b, len_c;
    logic [1:0]              idx;
    logic [STEP_W-1:0]       step;
    logic [DEN_W-1:0]        mag_q [3];
    logic [DEN_W-1:0]        den_q [3];
    logic [2:0]              neg_q;
    logic signed [COS_W-1:0] cos_q [3];
    logic                    invalid_q;
    logic [1:0]              tri_q;
    logic [DEN_W:0]          rem;
    logic [Q_W-1:0]          quo;

    // Squares, numerators and denominators evaluated during PREP
    logic signed [NUM_W-1:0] sq_a, sq_b, sq_c, num_a, num_b, num_c;
    logic [DEN_W-1:0]        den_a, den_b, den_c;
    logic [LEN_W:0]          sum_bc, sum_ac, sum_ab;
    logic                    bad, any_neg, any_zero;
    logic [1:0]              tri_nx;

    assign sq_a  = NUM_W'(len_a) * NUM_W'(len_a);
    assign sq_b  = NUM_W'(len_b) * NUM_W'(len_b);
    assign sq_c  = NUM_W'(len_c) * NUM_W'(len_c);
    assign num_a = sq_b + sq_c - sq_a;
    assign num_b = sq_a + sq_c - sq_b;
    assign num_c = sq_a + sq_b - sq_c;
    assign den_a = (DEN_W'(len_b) * DEN_W'(len_c)) << 1;
    assign den_b = (DEN_W'(len_a) * DEN_W'(len_c)) << 1;
    assign den_c = (DEN_W'(len_a) * DEN_W'(len_b)) << 1;

    assign sum_bc = {1'b0, len_b} + {1'b0, len_c};
    assign sum_ac = {1'b0, len_a} + {1'b0, len_c};
    assign sum_ab = {1'b0, len_a} + {1'b0, len_b};
    assign bad = (len_a == '0) || (len_b == '0) || (len_c == '0) ||
                 ({1'b0, len_a} >= sum_bc) || ({1'b0, len_b} >= sum_ac) ||
                 ({1'b0, len_c} >= sum_ab);
    assign any_neg  = num_a[NUM_W-1] | num_b[NUM_W-1] | num_c[NUM_W-1];
    assign any_zero = (num_a == '0) || (num_b == '0) || (num_c == '0);

    always_comb begin
        tri_nx = 2'b00;
        if (bad)           tri_nx = 2'b11;
        else if (any_neg)  tri_nx = 2'b10;
        else if (any_zero) tri_nx = 2'b01;
    end

    // One restoring divider step; step 0 of each angle starts from |num|
    logic [DEN_W:0]          rem_in, den_x, rem_sub;
    logic                    ge;
    logic [Q_W-1:0]          quo_nx;
    logic signed [COS_W-1:0] cos_mag, cos_val;

    assign rem_in  = (step == '0) ? {1'b0, mag_q[idx]} : rem;
    assign den_x   = {1'b0, den_q[idx]};
    assign ge      = (rem_in >= den_x);
    assign rem_sub = ge ? (rem_in - den_x) : rem_in;
    assign quo_nx  = {quo[Q_W-2:0], ge};
    assign cos_mag = COS_W'(quo_nx);
    assign cos_val = neg_q[idx] ? -cos_mag : cos_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = LOAD;
            LOAD: begin
                if (!in_valid)          state_nx = IDLE;
                else if (idx == 2'd1)   state_nx = PREP;
            end
            PREP: state_nx = DIV;
            DIV:  if (step == STEP_LAST && idx == 2'd2) state_nx = OUT;
            OUT:  if (idx == 2'd2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_a     <= '0;
            len_b     <= '0;
            len_c     <= '0;
            idx       <= '0;
            step      <= '0;
            neg_q     <= '0;
            invalid_q <= 1'b0;
            tri_q     <= '0;
            rem       <= '0;
            quo       <= '0;
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_tri   <= '0;
            for (int i = 0; i < 3; i++) begin
                mag_q[i] <= '0;
                den_q[i] <= '0;
                cos_q[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out_cos   <= '0;
            out_tri   <= '0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (in_valid) len_a <= in_length;
                end
                LOAD: begin
                    if (!in_valid) begin
                        idx <= '0;
                    end else if (idx == 2'd0) begin
                        len_b <= in_length;
                        idx   <= 2'd1;
                    end else begin
                        len_c <= in_length;
                        idx   <= 2'd0;
                    end
                end
                PREP: begin
                    mag_q[0]  <= num_a[NUM_W-1] ? DEN_W'(-num_a) : DEN_W'(num_a);
                    mag_q[1]  <= num_b[NUM_W-1] ? DEN_W'(-num_b) : DEN_W'(num_b);
                    mag_q[2]  <= num_c[NUM_W-1] ? DEN_W'(-num_c) : DEN_W'(num_c);
                    neg_q     <= {num_c[NUM_W-1], num_b[NUM_W-1], num_a[NUM_W-1]};
                    den_q[0]  <= den_a;
                    den_q[1]  <= den_b;
                    den_q[2]  <= den_c;
                    invalid_q <= bad;
                    tri_q     <= tri_nx;
                    step      <= '0;
                    idx       <= '0;
                end
                DIV: begin
                    rem <= rem_sub << 1;
                    quo <= quo_nx;
                    if (step == STEP_LAST) begin
                        cos_q[idx] <= cos_val;
                        step       <= '0;
                        idx        <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                OUT: begin
                    out_valid <= 1'b1;
                    out_cos   <= invalid_q ? '0 : cos_q[idx];
                    out_tri   <= tri_q;
                    idx       <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
                default: idx <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_tri_cos_param.sv
// Directed bench for tri_cos_param: hand-computed cosines, triangle types,
// burst latency, abort, busy-ignore and reset behaviour.
module tb_tri_cos_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_length;
    logic        out_valid;
    logic [15:0] out_cos;
    logic [1:0]  out_tri;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycles from the one presenting the third length to the first out_valid cycle
    localparam int LAT = 45;

    tri_cos_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_cos   (out_cos),
        .out_tri   (out_tri)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tri(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk); in_valid = 1'b1; in_length = a;
        @(negedge clk); in_length = b;
        @(negedge clk); in_length = c;
        @(negedge clk); in_valid = 1'b0; in_length = '0;
    endtask

    task automatic expect_burst(input string tag, input logic [1:0] exp_tri,
                                input logic [15:0] c0, input logic [15:0] c1,
                                input logic [15:0] c2);
        int lat;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_tri"}, 32'(out_tri), 32'(exp_tri));
        check({tag, "_cos0"}, 32'(out_cos), 32'(c0));
        @(negedge clk);
        check({tag, "_valid1"}, 32'(out_valid), 32'd1);
        check({tag, "_cos1"}, 32'(out_cos), 32'(c1));
        @(negedge clk);
        check({tag, "_valid2"}, 32'(out_valid), 32'd1);
        check({tag, "_cos2"}, 32'(out_cos), 32'(c2));
        @(negedge clk);
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_cos"}, 32'(out_cos), 32'd0);
        check({tag, "_end_tri"}, 32'(out_tri), 32'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_length = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_cos", 32'(out_cos), 32'd0);
        check("reset_tri", 32'(out_tri), 32'd0);
        rst_n = 1'b1;

        send_tri(8'd3, 8'd4, 8'd5);
        expect_burst("right_345", 2'b01, 16'd6553, 16'd4915, 16'd0);

        send_tri(8'd2, 8'd3, 8'd4);
        expect_burst("obtuse_234", 2'b10, 16'd7168, 16'd5632, 16'hF800);

        send_tri(8'd10, 8'd10, 8'd10);
        expect_burst("equi_10", 2'b00, 16'd4096, 16'd4096, 16'd4096);

        send_tri(8'd255, 8'd255, 8'd255);
        expect_burst("equi_255", 2'b00, 16'd4096, 16'd4096, 16'd4096);

        send_tri(8'd1, 8'd2, 8'd3);
        expect_burst("degen_123", 2'b11, 16'd0, 16'd0, 16'd0);

        send_tri(8'd0, 8'd5, 8'd5);
        expect_burst("zero_055", 2'b11, 16'd0, 16'd0, 16'd0);

        // Aborted after two lengths: nothing must come out
        @(negedge clk); in_valid = 1'b1; in_length = 8'd5;
        @(negedge clk); in_length = 8'd5;
        @(negedge clk); in_valid = 1'b0; in_length = '0;
        watch_quiet("abort_quiet", 60);

        // Extra triple pulse while the divider is busy must be ignored
        send_tri(8'd3, 8'd4, 8'd5);
        fork
            begin
                repeat (10) @(negedge clk);
                in_valid = 1'b1; in_length = 8'd7;
                repeat (3) @(negedge clk);
                in_valid = 1'b0; in_length = '0;
            end
        join_none
        expect_burst("busy_345", 2'b01, 16'd6553, 16'd4915, 16'd0);
        watch_quiet("busy_quiet", 60);

        // Reset in the middle of the divide
        send_tri(8'd3, 8'd4, 8'd5);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_div_valid", 32'(out_valid), 32'd0);
        check("rst_div_cos", 32'(out_cos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_div_quiet", 60);
        send_tri(8'd3, 8'd4, 8'd5);
        expect_burst("after_rst_345", 2'b01, 16'd6553, 16'd4915, 16'd0);

        // Reset in the middle of a burst clears the outputs at once
        send_tri(8'd2, 8'd3, 8'd4);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_burst_seen", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_burst_valid", 32'(out_valid), 32'd0);
        check("rst_burst_cos", 32'(out_cos), 32'd0);
        check("rst_burst_tri", 32'(out_tri), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_burst_quiet", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
